// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver on the same link.
//   uart_state_e    : frame-sequencing states (PARITY only reachable when the
//                     UART_TX_PARITY_EN macro is defined in the transmitter)
//   UART_DATA_BITS  : payload bits per frame
//   UART_IDLE_LEVEL : line level between frames and during stop bits
//   even_parity()   : parity bit that makes the count of ones even
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_e;

   function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Free-running bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps, raising
// tick for the single cycle in which the count sits at its last value.
//   clk   : system clock
//   rst   : synchronous active-high reset (count -> 0)
//   clear : synchronous clear, restarts the bit period from 0
//   tick  : one-cycle pulse marking the last cycle of a bit period
// Parameters: CLKS_PER_BIT (2..65535)
// -----------------------------------------------------------------------------
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // tick is taken from the count alone so that clear (which the parent derives
   // from a state change caused by tick) never feeds back into tick.
   assign tick = (cnt_q == LAST_COUNT);

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clear || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
// Serial frame generator: start bit (0), 8 data bits LSB first, optional even
// parity bit, STOP_BITS stop bits (1). Each bit lasts CLKS_PER_BIT cycles.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   in_data  : byte to transmit, sampled only on the accept cycle
//   in_valid : in_data valid
//   in_ready : high while idle; a byte is accepted when in_valid && in_ready
//   tx       : serial line, registered, idles high
//   busy     : frame in progress
//   done     : one-cycle pulse on the cycle after the last stop bit
// Parameters: CLKS_PER_BIT (2..65535), STOP_BITS (1 or 2)
// Build option: define UART_TX_PARITY_EN to send an even-parity bit after the
// data bits; without it the PARITY state logic is compiled out.
// -----------------------------------------------------------------------------
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [UART_DATA_BITS-1:0] in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic                      tx,
   output logic                      busy,
   output logic                      done
);

   localparam logic [2:0] LAST_DATA_BIT = 3'(UART_DATA_BITS - 1);
   localparam logic [2:0] LAST_STOP_BIT = 3'(STOP_BITS - 1);

   uart_state_e               state_q, state_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic [2:0]                bit_cnt_q, bit_cnt_d;
   logic                      tx_q, tx_d;
   logic                      done_q, done_d;
`ifdef UART_TX_PARITY_EN
   logic                      parity_q, parity_d;
`endif

   logic bit_tick;
   logic baud_clear;

   // Restarting the bit period on every state entry guarantees a full-length
   // first bit; holding it cleared in IDLE keeps the count at 0 until accept.
   assign baud_clear = (state_q == IDLE) || (state_d != state_q);

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_tick (
      .clk  (clk),
      .rst  (rst),
      .clear(baud_clear),
      .tick (bit_tick)
   );

   assign in_ready = (state_q == IDLE);
   assign busy     = (state_q != IDLE);
   assign tx       = tx_q;
   assign done     = done_q;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               shift_d   = in_data;
               bit_cnt_d = '0;
               state_d   = START;
`ifdef UART_TX_PARITY_EN
               parity_d  = even_parity(in_data);
`endif
            end
         end
         START: begin
            if (bit_tick) begin
               bit_cnt_d = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (bit_tick) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == LAST_DATA_BIT) begin
                  bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d   = PARITY;
`else
                  state_d   = STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_tick) begin
               bit_cnt_d = '0;
               state_d   = STOP;
            end
         end
`endif
         STOP: begin
            // bit_cnt counts completed stop bits so 2-stop-bit frames reuse it.
            if (bit_tick) begin
               if (bit_cnt_q == LAST_STOP_BIT) begin
                  bit_cnt_d = '0;
                  done_d    = 1'b1;
                  state_d   = IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // tx is registered from the next-state view so the line changes on the same
   // edge as the state, e.g. it falls on the edge that accepts a byte.
   always_comb begin
      tx_d = UART_IDLE_LEVEL;
      case (state_d)
         START:   tx_d = ~UART_IDLE_LEVEL;
         DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_d = parity_d;
`endif
         default: tx_d = UART_IDLE_LEVEL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         tx_q      <= UART_IDLE_LEVEL;
         done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
// Drives two transmitters (STOP_BITS=1 and STOP_BITS=2, CLKS_PER_BIT=4) from the
// same inputs and compares every output on every cycle against a frame-position
// model, plus literal expectations for hand-worked frames.
// Honours UART_TX_PARITY_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_uart_transmitter;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int PAR       = 1;
   localparam int DONE0_LIT = 44;
   localparam int DONE1_LIT = 48;
`else
   localparam int PAR       = 0;
   localparam int DONE0_LIT = 40;
   localparam int DONE1_LIT = 44;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic [1:0] rdy_o, tx_o, busy_o, done_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_transmitter #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy_o[0]), .tx(tx_o[0]), .busy(busy_o[0]), .done(done_o[0])
   );

   uart_transmitter #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy_o[1]), .tx(tx_o[1]), .busy(busy_o[1]), .done(done_o[1])
   );

   // Model state, one slot per DUT: frame cycle position and the latched byte.
   logic       busy_m [2] = '{1'b0, 1'b0};
   logic       done_m [2] = '{1'b0, 1'b0};
   logic       tx_m   [2] = '{1'b1, 1'b1};
   logic [7:0] byte_m [2] = '{8'h00, 8'h00};
   int         pos_m  [2] = '{0, 0};
   logic       check_en = 1'b0;

   // Bit index 0 is the start bit, 1..8 are data LSB first, then parity if
   // enabled, and everything after that is stop level.
   function automatic logic frameBit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      if (PAR == 1 && idx == 9) return ^b;
      return 1'b1;
   endfunction

   function automatic int frameLen(input int s);
      return (9 + PAR + s + 1) * CPB;
   endfunction

   // Reference model: advances one frame cycle per clock, accepts only when idle,
   // and flags done on the cycle after the frame length has elapsed.
   always @(posedge clk) begin
      if (rst) check_en <= 1'b1;
      for (int s = 0; s < 2; s++) begin
         if (rst) begin
            busy_m[s] <= 1'b0;
            done_m[s] <= 1'b0;
            tx_m[s]   <= 1'b1;
         end else if (!busy_m[s]) begin
            done_m[s] <= 1'b0;
            if (in_valid) begin
               byte_m[s] <= in_data;
               pos_m[s]  <= 0;
               busy_m[s] <= 1'b1;
               tx_m[s]   <= frameBit(in_data, 0);
            end else begin
               tx_m[s] <= 1'b1;
            end
         end else if (pos_m[s] + 1 == frameLen(s)) begin
            busy_m[s] <= 1'b0;
            done_m[s] <= 1'b1;
            tx_m[s]   <= 1'b1;
         end else begin
            pos_m[s]  <= pos_m[s] + 1;
            done_m[s] <= 1'b0;
            tx_m[s]   <= frameBit(byte_m[s], (pos_m[s] + 1) / CPB);
         end
      end
   end

   // Compare every output of both DUTs against the model on each falling edge.
   always @(negedge clk) begin
      if (check_en) begin
         for (int s = 0; s < 2; s++) begin
            checkOutput($sformatf("tx%0d", s),    tx_o[s],   tx_m[s]);
            checkOutput($sformatf("busy%0d", s),  busy_o[s], busy_m[s]);
            checkOutput($sformatf("ready%0d", s), rdy_o[s],  !busy_m[s]);
            checkOutput($sformatf("done%0d", s),  done_o[s], done_m[s]);
         end
      end
   end

   task automatic checkOutput(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
      end
   endtask

   // Bounded wait for both transmitters to be idle; returns on a falling edge.
   task automatic waitIdle();
      int n;
      n = 0;
      while (!(rdy_o[0] && rdy_o[1]) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("[TB] FAIL idle_timeout actual=busy expected=idle at %0t", $time);
      end
   endtask

   // Offers one byte for a single cycle; returns on the falling edge just after
   // the accepting edge (frame cycle 0).
   task automatic applyStimulus(input logic [7:0] b);
      waitIdle();
      in_data  = b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   logic lit_a5 [11];
   int   nb;

   initial begin
`ifdef UART_TX_PARITY_EN
      lit_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
      lit_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
`endif
      nb = 10 + PAR;
      $display("[TB] reset and idle");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("idle_tx", tx_o[0], 1'b1);

      $display("[TB] frame 8'hA5");
      applyStimulus(8'hA5);
      for (int k = 1; k <= DONE1_LIT + 2; k++) begin
         if (k > 1) @(negedge clk);
         if ((k - 1) % CPB == 2 && (k - 1) / CPB < nb) begin
            checkOutput("a5_bit", tx_o[0], lit_a5[(k - 1) / CPB]);
            checkOutput("a5_model", tx_m[0], lit_a5[(k - 1) / CPB]);
         end
         if (k == DONE0_LIT) checkOutput("a5_early_done", done_o[0], 1'b0);
         if (k == DONE0_LIT + 1) begin
            checkOutput("a5_done", done_o[0], 1'b1);
            checkOutput("a5_ready_with_done", rdy_o[0], 1'b1);
         end
         if (k == DONE1_LIT + 1) checkOutput("a5_done_stop2", done_o[1], 1'b1);
      end

`ifdef UART_TX_PARITY_EN
      $display("[TB] parity of 8'h07");
      applyStimulus(8'h07);
      for (int k = 2; k <= 9 * CPB + 3; k++) @(negedge clk);
      checkOutput("p07_parity", tx_o[0], 1'b1);
`endif

      $display("[TB] back-to-back 8'h00 then 8'hFF");
      waitIdle();
      in_data  = 8'h00;
      in_valid = 1'b1;
      @(negedge clk);
      in_data = 8'hFF;
      for (int k = 2; k <= 100; k++) begin
         @(negedge clk);
         if (k == DONE0_LIT + 1) checkOutput("b2b_gap_tx", tx_o[0], 1'b1);
         if (k == DONE0_LIT + 2) begin
            checkOutput("b2b_start_tx", tx_o[0], 1'b0);
            checkOutput("b2b_start_busy", busy_o[0], 1'b1);
         end
         if (k == DONE0_LIT + 20) in_data = 8'h5A;
      end
      in_valid = 1'b0;

      $display("[TB] reset during data bit 3");
      applyStimulus(8'hC3);
      repeat (17) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rst_tx", tx_o[0], 1'b1);
      checkOutput("rst_busy", busy_o[0], 1'b0);
      checkOutput("rst_done", done_o[0], 1'b0);
      repeat (60) @(negedge clk);
      applyStimulus(8'h3C);
      repeat (DONE1_LIT + 4) @(negedge clk);

      $display("[TB] random traffic");
      for (int i = 0; i < 1500; i++) begin
         in_data  = 8'($urandom);
         in_valid = ($urandom_range(0, 3) == 0);
         rst      = ($urandom_range(0, 299) == 0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      rst      = 1'b0;
      waitIdle();
      repeat (4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
